// File: rtl/unary_rate_tx_if.sv
// ----------------------------------------------------------------------------
// unary_rate_tx_if
//   Bundles the operand handshake and the stream/chain-control outputs of the
//   unary-rate edge transmitter. clk and rst stay plain ports on the module.
//
//   Signals
//     i_valid      operand valid                     (master -> slave)
//     i_ready      transmitter can accept            (slave  -> master)
//     i_data       signed operand, DATA_WIDTH bits   (master -> slave)
//     i_stall      freeze the stream                 (master -> slave)
//     o_en         chain enable / stream bit strobe  (slave  -> master)
//     o_clr        chain clear pulse                 (slave  -> master)
//     o_data_sign  operand sign, valid with o_en     (slave  -> master)
//     o_data_dff   rate-coded data bit, valid w/ o_en(slave  -> master)
//     o_done       end-of-operand pulse              (slave  -> master)
//
//   Modports
//     master  operand source / stream consumer side
//     slave   transmitter side
// ----------------------------------------------------------------------------
interface unary_rate_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         i_valid;
    logic                         i_ready;
    logic signed [DATA_WIDTH-1:0] i_data;
    logic                         i_stall;
    logic                         o_en;
    logic                         o_clr;
    logic                         o_data_sign;
    logic                         o_data_dff;
    logic                         o_done;

    modport master (
        output i_valid, i_data, i_stall,
        input  i_ready, o_en, o_clr, o_data_sign, o_data_dff, o_done
    );

    modport slave (
        input  i_valid, i_data, i_stall,
        output i_ready, o_en, o_clr, o_data_sign, o_data_dff, o_done
    );
endinterface

// File: rtl/unary_rate_tx.sv
// ----------------------------------------------------------------------------
// unary_rate_tx
//   Edge transmitter for a unary-rate systolic row. Takes one signed operand
//   over valid/ready and emits it as a sign bit plus a 2^CNT_WIDTH-cycle
//   rate-coded bitstream whose ones-count equals the operand magnitude
//   exactly. Also generates the en/clr controls for the horizontal
//   input-register chain.
//
//   Parameters
//     DATA_WIDTH  two's-complement operand width
//     CNT_WIDTH   stream-length exponent, must be DATA_WIDTH-1
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   unary_rate_tx_if.slave (handshake, stall, stream outputs)
//
//   Build option
//     ZERO_SKIP_EN  when defined, a zero-magnitude operand skips the stream
//                   phase entirely (CLR then DONE, o_en never asserted).
//
//   State table
//     state    | meaning
//     S_IDLE   | ready for an operand; i_ready=1
//     S_CLR    | one-cycle chain clear pulse
//     S_STREAM | emitting rate-coded bits, one per unstalled cycle
//     S_DONE   | one-cycle end-of-operand pulse
// ----------------------------------------------------------------------------
module unary_rate_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 7
) (
    input  logic           clk,
    input  logic           rst,
    unary_rate_tx_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLR    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] mag, mag_nxt;
    logic                 sign, sign_nxt;

    logic [CNT_WIDTH-1:0]  cnt_rev;
    logic [DATA_WIDTH-1:0] abs_val;
    logic [CNT_WIDTH-1:0]  mag_in;

    // Comparing against the bit-reversed count spreads the ones evenly over
    // the stream while keeping the total exactly equal to mag.
    always_comb begin
        cnt_rev = '0;
        for (int k = 0; k < CNT_WIDTH; k++) begin
            cnt_rev[k] = cnt[CNT_WIDTH-1-k];
        end
    end

    // Only the most negative operand leaves the MSB set after negation; it
    // saturates to the largest representable magnitude.
    assign abs_val = bus.i_data[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - bus.i_data)
                                              : bus.i_data;
    assign mag_in  = abs_val[DATA_WIDTH-1] ? CNT_LAST : abs_val[CNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            mag   <= '0;
            sign  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mag   <= mag_nxt;
            sign  <= sign_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        mag_nxt         = mag;
        sign_nxt        = sign;
        bus.i_ready     = 1'b0;
        bus.o_en        = 1'b0;
        bus.o_clr       = 1'b0;
        bus.o_data_sign = 1'b0;
        bus.o_data_dff  = 1'b0;
        bus.o_done      = 1'b0;

        case (state)
            S_IDLE: begin
                bus.i_ready = 1'b1;
                if (bus.i_valid) begin
                    sign_nxt  = bus.i_data[DATA_WIDTH-1];
                    mag_nxt   = mag_in;
                    cnt_nxt   = '0;
                    state_nxt = S_CLR;
                end
            end

            S_CLR: begin
                bus.o_clr = 1'b1;
`ifdef ZERO_SKIP_EN
                state_nxt = (mag == '0) ? S_DONE : S_STREAM;
`else
                state_nxt = S_STREAM;
`endif
            end

            S_STREAM: begin
                bus.o_en        = ~bus.i_stall;
                bus.o_data_sign = sign & ~bus.i_stall;
                bus.o_data_dff  = ~bus.i_stall & (mag > cnt_rev);
                if (!bus.i_stall) begin
                    // Wraps to zero on the last bit, ready for the next operand.
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                bus.o_done = 1'b1;
                state_nxt  = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_unary_rate_tx.sv
// ----------------------------------------------------------------------------
// tb_unary_rate_tx
//   Directed self-checking bench for unary_rate_tx. Inputs are driven 1 time
//   unit after the rising edge and outputs sampled 2 time units after it.
// ----------------------------------------------------------------------------
module tb_unary_rate_tx;

    logic clk;
    logic rst;

    unary_rate_tx_if #(.DATA_WIDTH(8)) bus ();

    unary_rate_tx #(.DATA_WIDTH(8), .CNT_WIDTH(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int           wait_cyc;
        int           clr_cyc;
        int           first_en;
        int           en_cnt;
        int           ones;
        int           sign_cnt;
        int           done_cyc;
        int           stall_cnt;
        int           leak;
        int           busy_ready;
        logic [127:0] map;
        bit           timeout;
    } res_t;

    // Offers one operand, then records the stream cycle by cycle, relative to
    // the accept cycle (t=0), until o_done is seen.
    task automatic collect(input logic signed [7:0] d, input int stall_period,
                           input bit hold_valid, output res_t r);
        bit seen_done;
        r.wait_cyc = 0; r.clr_cyc = -1; r.first_en = -1; r.en_cnt = 0;
        r.ones = 0; r.sign_cnt = 0; r.done_cyc = -1; r.stall_cnt = 0;
        r.leak = 0; r.busy_ready = 0; r.map = '0; r.timeout = 1'b0;
        seen_done = 1'b0;
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.i_data = d; bus.i_stall = 1'b0;
        #1;
        while (!bus.i_ready && r.wait_cyc < 300) begin
            @(posedge clk); #2;
            r.wait_cyc++;
        end
        if (!bus.i_ready) begin
            r.timeout = 1'b1;
            bus.i_valid = 1'b0;
            return;
        end
        for (int t = 1; t <= 400 && !seen_done; t++) begin
            @(posedge clk); #1;
            if (!hold_valid) bus.i_valid = 1'b0;
            bus.i_stall = (stall_period > 0) && (t % stall_period == 0);
            #1;
            if (bus.i_ready) r.busy_ready++;
            if (bus.o_clr && r.clr_cyc < 0) r.clr_cyc = t;
            if (bus.i_stall && r.clr_cyc >= 0 && t > r.clr_cyc && r.en_cnt < 128 && !bus.o_done) begin
                r.stall_cnt++;
                if (bus.o_en) r.leak++;
            end
            if (!bus.o_en && (bus.o_data_dff || bus.o_data_sign)) r.leak++;
            if (bus.o_en) begin
                if (r.first_en < 0) r.first_en = t;
                if (r.en_cnt < 128) r.map[r.en_cnt] = bus.o_data_dff;
                r.ones     += int'(bus.o_data_dff);
                r.sign_cnt += int'(bus.o_data_sign);
                r.en_cnt++;
            end
            if (bus.o_done) begin
                r.done_cyc = t;
                seen_done  = 1'b1;
            end
        end
        bus.i_stall = 1'b0;
        if (!seen_done) r.timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (bus.i_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.i_ready); end
        n_cmp++; if ({bus.o_en, bus.o_clr, bus.o_data_sign, bus.o_data_dff, bus.o_done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_outs got=%b want=00000", {bus.o_en, bus.o_clr, bus.o_data_sign, bus.o_data_dff, bus.o_done});
        end
        // An operand offered during reset must not be taken.
        bus.i_valid = 1'b1; bus.i_data = 8'sd9;
        @(posedge clk); #2;
        n_cmp++; if (bus.o_clr !== 1'b0 || bus.i_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_priority got clr=%b ready=%b want clr=0 ready=1", bus.o_clr, bus.i_ready);
        end
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_positive();
        res_t r;
        logic [127:0] exp_map;
        exp_map = '0;
        exp_map[0] = 1'b1; exp_map[16] = 1'b1; exp_map[32] = 1'b1; exp_map[64] = 1'b1; exp_map[96] = 1'b1;
        collect(8'sd5, 0, 1'b0, r);
        n_cmp++; if (r.timeout !== 1'b0) begin n_bad++; $display("FAIL pos5_timeout got=%b want=0", r.timeout); end
        n_cmp++; if (r.wait_cyc !== 0) begin n_bad++; $display("FAIL pos5_accept_wait got=%0d want=0", r.wait_cyc); end
        n_cmp++; if (r.clr_cyc !== 1) begin n_bad++; $display("FAIL pos5_clr_cycle got=%0d want=1", r.clr_cyc); end
        n_cmp++; if (r.first_en !== 2) begin n_bad++; $display("FAIL pos5_first_en got=%0d want=2", r.first_en); end
        n_cmp++; if (r.en_cnt !== 128) begin n_bad++; $display("FAIL pos5_en_count got=%0d want=128", r.en_cnt); end
        n_cmp++; if (r.sign_cnt !== 0) begin n_bad++; $display("FAIL pos5_sign got=%0d want=0", r.sign_cnt); end
        n_cmp++; if (r.map !== exp_map) begin n_bad++; $display("FAIL pos5_map got=%h want=%h", r.map, exp_map); end
        n_cmp++; if (r.done_cyc !== 130) begin n_bad++; $display("FAIL pos5_done_cycle got=%0d want=130", r.done_cyc); end
        n_cmp++; if (r.busy_ready !== 0) begin n_bad++; $display("FAIL pos5_busy_ready got=%0d want=0", r.busy_ready); end
    endtask

    task automatic test_negative();
        res_t r;
        collect(-8'sd128, 0, 1'b0, r);
        n_cmp++; if (r.timeout !== 1'b0) begin n_bad++; $display("FAIL neg128_timeout got=%b want=0", r.timeout); end
        n_cmp++; if (r.sign_cnt !== 128) begin n_bad++; $display("FAIL neg128_sign got=%0d want=128", r.sign_cnt); end
        n_cmp++; if (r.ones !== 127) begin n_bad++; $display("FAIL neg128_ones got=%0d want=127", r.ones); end
        n_cmp++; if (r.map[127] !== 1'b0) begin n_bad++; $display("FAIL neg128_last_bit got=%b want=0", r.map[127]); end
        collect(-8'sd1, 0, 1'b0, r);
        n_cmp++; if (r.timeout !== 1'b0) begin n_bad++; $display("FAIL neg1_timeout got=%b want=0", r.timeout); end
        n_cmp++; if (r.sign_cnt !== 128) begin n_bad++; $display("FAIL neg1_sign got=%0d want=128", r.sign_cnt); end
        n_cmp++; if (r.map !== 128'h1) begin n_bad++; $display("FAIL neg1_map got=%h want=%h", r.map, 128'h1); end
    endtask

    task automatic test_stall();
        res_t r;
        collect(8'sd100, 3, 1'b0, r);
        n_cmp++; if (r.timeout !== 1'b0) begin n_bad++; $display("FAIL stall_timeout got=%b want=0", r.timeout); end
        n_cmp++; if (r.en_cnt !== 128) begin n_bad++; $display("FAIL stall_en_count got=%0d want=128", r.en_cnt); end
        n_cmp++; if (r.ones !== 100) begin n_bad++; $display("FAIL stall_ones got=%0d want=100", r.ones); end
        n_cmp++; if (r.leak !== 0) begin n_bad++; $display("FAIL stall_leak got=%0d want=0", r.leak); end
        n_cmp++; if (r.done_cyc !== 130 + r.stall_cnt) begin
            n_bad++; $display("FAIL stall_done_cycle got=%0d want=%0d", r.done_cyc, 130 + r.stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        int idx;
        logic [127:0] exp_map;
        exp_map = '0;
        exp_map[0] = 1'b1; exp_map[16] = 1'b1; exp_map[32] = 1'b1; exp_map[64] = 1'b1; exp_map[96] = 1'b1;
        idx = -1;
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.i_data = 8'sd100;
        for (int t = 0; t < 300 && idx < 40; t++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            #1;
            if (bus.o_en) idx++;
        end
        n_cmp++; if (idx !== 40) begin n_bad++; $display("FAIL rstmid_reach_idx got=%0d want=40", idx); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.i_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", bus.i_ready); end
        n_cmp++; if ({bus.o_en, bus.o_clr, bus.o_data_sign, bus.o_data_dff, bus.o_done} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_outs got=%b want=00000", {bus.o_en, bus.o_clr, bus.o_data_sign, bus.o_data_dff, bus.o_done});
        end
        collect(8'sd5, 0, 1'b0, r);
        n_cmp++; if (r.map !== exp_map) begin n_bad++; $display("FAIL rstmid_restream_map got=%h want=%h", r.map, exp_map); end
        n_cmp++; if (r.en_cnt !== 128) begin n_bad++; $display("FAIL rstmid_restream_en got=%0d want=128", r.en_cnt); end
    endtask

    task automatic test_zero();
        res_t r;
        collect(8'sd0, 0, 1'b0, r);
        n_cmp++; if (r.timeout !== 1'b0) begin n_bad++; $display("FAIL zero_timeout got=%b want=0", r.timeout); end
        n_cmp++; if (r.clr_cyc !== 1) begin n_bad++; $display("FAIL zero_clr_cycle got=%0d want=1", r.clr_cyc); end
        n_cmp++; if (r.ones !== 0 || r.sign_cnt !== 0) begin
            n_bad++; $display("FAIL zero_bits got ones=%0d sign=%0d want 0/0", r.ones, r.sign_cnt);
        end
`ifdef ZERO_SKIP_EN
        n_cmp++; if (r.en_cnt !== 0) begin n_bad++; $display("FAIL zero_en_count got=%0d want=0", r.en_cnt); end
        n_cmp++; if (r.done_cyc !== 2) begin n_bad++; $display("FAIL zero_done_cycle got=%0d want=2", r.done_cyc); end
`else
        n_cmp++; if (r.en_cnt !== 128) begin n_bad++; $display("FAIL zero_en_count got=%0d want=128", r.en_cnt); end
        n_cmp++; if (r.done_cyc !== 130) begin n_bad++; $display("FAIL zero_done_cycle got=%0d want=130", r.done_cyc); end
`endif
    endtask

    task automatic test_back_to_back();
        res_t r1;
        res_t r2;
        collect(8'sd3, 0, 1'b1, r1);
        collect(-8'sd7, 0, 1'b1, r2);
        bus.i_valid = 1'b0;
        n_cmp++; if (r1.busy_ready !== 0) begin n_bad++; $display("FAIL b2b_busy_ready got=%0d want=0", r1.busy_ready); end
        n_cmp++; if (r2.wait_cyc !== 0) begin n_bad++; $display("FAIL b2b_second_accept_wait got=%0d want=0", r2.wait_cyc); end
        n_cmp++; if (r1.ones !== 3 || r1.sign_cnt !== 0) begin
            n_bad++; $display("FAIL b2b_first got ones=%0d sign=%0d want 3/0", r1.ones, r1.sign_cnt);
        end
        n_cmp++; if (r2.ones !== 7 || r2.sign_cnt !== 128) begin
            n_bad++; $display("FAIL b2b_second got ones=%0d sign=%0d want 7/128", r2.ones, r2.sign_cnt);
        end
        n_cmp++; if (r1.done_cyc !== 130 || r2.done_cyc !== 130) begin
            n_bad++; $display("FAIL b2b_done_cycle got %0d,%0d want 130,130", r1.done_cyc, r2.done_cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_stall = 1'b0;
        test_reset();
        test_positive();
        test_negative();
        test_stall();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
